// File: rtl/pc_sn_stream_top_if.sv
// Generic valid/ready stream bundle used on both sides of pc_sn_stream_top.
//   data   W-bit payload
//   valid  payload valid (driven by master)
//   ready  sink can take the beat (driven by slave); transfer on valid && ready
interface pc_sn_stream_top_if #(
  parameter int unsigned W = 7
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pc_sn_stream_top.sv
// Streaming ones-counter. Each accepted N-bit word is sorted into a thermometer code
// (bit-level odd-even transposition network), registered, then encoded to a binary
// count in a second register stage. Valid/ready backpressure on both sides; an optional
// saturating accumulator sums the counts of delivered beats.
// Ports:
//   clk, rst_n       single clock, asynchronous active-low reset
//   in_bus (slave)   N-bit words in; ready is combinational from out_bus.ready
//   out_bus (master) OW-bit count of ones out
//   acc_en           add each delivered count into acc
//   acc_clr          synchronous clear of acc/acc_sat (clear-then-add on a delivery)
//   acc, acc_sat     running sum of delivered counts; sticky saturation flag
module pc_sn_stream_top #(
  parameter int unsigned N     = 7,
  parameter int unsigned OW    = 3,
  parameter int unsigned ACC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_sn_stream_top_if.slave   in_bus,
  pc_sn_stream_top_if.master  out_bus,
  input  logic                acc_en,
  input  logic                acc_clr,
  output logic [ACC_W-1:0]    acc,
  output logic                acc_sat
);

  if (OW != $clog2(N + 1)) begin : g_bad_ow
    $error("pc_sn_stream_top: OW must equal $clog2(N+1)");
  end
  if (N < 2) begin : g_bad_n
    $error("pc_sn_stream_top: N must be at least 2");
  end
  if (ACC_W < OW) begin : g_bad_acc_w
    $error("pc_sn_stream_top: ACC_W must be at least OW");
  end

  logic [N-1:0]     therm_q;
  logic             v1_q;
  logic [OW-1:0]    count_q;
  logic             v2_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  logic             s2_free, s1_move, in_ready, accept, deliver;
  logic [N-1:0]     sorted;
  logic [OW-1:0]    count_d;
  logic [ACC_W:0]   sum;

  // Pipeline control: no skid buffer, so ready ripples straight back from the sink.
  assign s2_free  = !v2_q || out_bus.ready;
  assign s1_move  = v1_q && s2_free;
  assign in_ready = !v1_q || s2_free;
  assign accept   = in_bus.valid && in_ready;
  assign deliver  = v2_q && out_bus.ready && acc_en;

  assign in_bus.ready  = in_ready;
  assign out_bus.data  = count_q;
  assign out_bus.valid = v2_q;
  assign acc           = acc_q;
  assign acc_sat       = sat_q;

  // Odd-even transposition sort on single bits: compare-exchange is (OR, AND), which
  // gathers all ones at the low indices. N rounds suffice for N elements.
  always_comb begin
    sorted = in_bus.data;
    for (int r = 0; r < int'(N); r++) begin
      for (int j = r % 2; j + 1 < int'(N); j += 2) begin
        {sorted[j+1], sorted[j]} = {sorted[j] & sorted[j+1], sorted[j] | sorted[j+1]};
      end
    end
  end

  // Thermometer to binary: the highest set index + 1 is the number of ones.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (therm_q[i]) count_d = OW'(i + 1);
    end
  end

  // One extra bit catches overflow past all-ones.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - OW){1'b0}}, count_q};

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (acc_clr) begin
      acc_d = deliver ? {{(ACC_W - OW){1'b0}}, count_q} : '0;
      sat_d = 1'b0;
    end else if (deliver) begin
      if (sum[ACC_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      therm_q <= '0;
      v1_q    <= 1'b0;
      count_q <= '0;
      v2_q    <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (accept) therm_q <= sorted;
      v1_q <= accept ? 1'b1 : (s1_move ? 1'b0 : v1_q);
      if (s1_move) count_q <= count_d;
      v2_q <= s1_move ? 1'b1 : (out_bus.ready ? 1'b0 : v2_q);
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_pc_sn_stream_top.sv
module tb_pc_sn_stream_top;
  localparam int unsigned N     = 7;
  localparam int unsigned OW    = 3;
  localparam int unsigned ACC_W = 4;

  logic             clk;
  logic             rst_n;
  logic             acc_en;
  logic             acc_clr;
  logic [ACC_W-1:0] acc;
  logic             acc_sat;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_beats = 0;
  logic [OW-1:0] exp_q[$];

  pc_sn_stream_top_if #(.W(N))  in_bus ();
  pc_sn_stream_top_if #(.W(OW)) out_bus ();

  pc_sn_stream_top #(.N(N), .OW(OW), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus),
    .out_bus (out_bus),
    .acc_en  (acc_en),
    .acc_clr (acc_clr),
    .acc     (acc),
    .acc_sat (acc_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push the reference popcount on accept, pop and compare on delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_bus.valid && in_bus.ready) exp_q.push_back(OW'($countones(in_bus.data)));
      if (out_bus.valid && out_bus.ready) begin
        n_beats++;
        if (exp_q.size() == 0) check("beat_expected", 32'd0, 32'd1);
        else check("beat_count", 32'(out_bus.data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [N-1:0] w);
    int   k  = 0;
    logic ok = 1'b0;
    in_bus.data  = w;
    in_bus.valid = 1'b1;
    while (!ok && k < 50) begin
      @(negedge clk);
      ok = in_bus.ready;
      @(posedge clk);
      #1;
      k++;
    end
    in_bus.valid = 1'b0;
    in_bus.data  = 'x;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n         = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    out_bus.ready = 1'b1;
    acc_en        = 1'b0;
    acc_clr       = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_bus.valid), 32'd0);
    check("rst_out_count", 32'(out_bus.data), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_acc_sat", 32'(acc_sat), 32'd0);
    check("rst_in_ready", 32'(in_bus.ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: latency
    in_bus.data  = 7'b1011001;
    in_bus.valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 32'(in_bus.ready), 32'd1);
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
    in_bus.data  = 'x;
    check("lat_valid_k", 32'(out_bus.valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid_k1", 32'(out_bus.valid), 32'd1);
    check("lat_count", 32'(out_bus.data), 32'd4);
    @(posedge clk);
    #1;
    check("lat_valid_k2", 32'(out_bus.valid), 32'd0);

    // 2: exhaustive back-to-back
    base = n_beats;
    for (int i = 0; i < 128; i++) begin
      in_bus.data  = N'(i);
      in_bus.valid = 1'b1;
      @(negedge clk);
      check("exh_in_ready", 32'(in_bus.ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_bus.valid = 1'b0;
    drain();
    check("exh_beats", 32'(n_beats - base), 32'd128);

    // 3: backpressure
    base = n_beats;
    out_bus.ready = 1'b0;
    send(7'h7F);
    send(7'h00);
    in_bus.data  = 7'h55;
    in_bus.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_bus.ready), 32'd0);
      check("bp_out_valid", 32'(out_bus.valid), 32'd1);
      check("bp_count_held", 32'(out_bus.data), 32'd7);
      @(posedge clk);
      #1;
    end
    out_bus.ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_rel", 32'(in_bus.ready), 32'd1);
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
    in_bus.data  = 'x;
    drain();
    check("bp_beats", 32'(n_beats - base), 32'd3);

    // 4: saturation
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("sat_clr_acc", 32'(acc), 32'd0);
    acc_en = 1'b1;
    send(7'h7F);
    drain();
    check("sat_acc_7", 32'(acc), 32'd7);
    check("sat_flag_7", 32'(acc_sat), 32'd0);
    send(7'h7F);
    drain();
    check("sat_acc_14", 32'(acc), 32'd14);
    check("sat_flag_14", 32'(acc_sat), 32'd0);
    send(7'h7F);
    drain();
    check("sat_acc_15", 32'(acc), 32'd15);
    check("sat_flag_15", 32'(acc_sat), 32'd1);
    send(7'h01);
    drain();
    check("sat_acc_hold", 32'(acc), 32'd15);
    check("sat_flag_hold", 32'(acc_sat), 32'd1);

    // 5: clear + add in the same cycle
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("ca_clr_sat", 32'(acc_sat), 32'd0);
    send(7'h7F);
    drain();
    send(7'h03);
    drain();
    check("ca_acc_9", 32'(acc), 32'd9);
    out_bus.ready = 1'b0;
    send(7'h07);
    @(posedge clk);
    #1;
    check("ca_staged_valid", 32'(out_bus.valid), 32'd1);
    check("ca_staged_count", 32'(out_bus.data), 32'd3);
    acc_clr       = 1'b1;
    out_bus.ready = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("ca_acc_3", 32'(acc), 32'd3);
    check("ca_sat_0", 32'(acc_sat), 32'd0);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("ca_clr_only", 32'(acc), 32'd0);

    // acc_en=0 holds acc while beats still deliver
    send(7'h7F);
    drain();
    check("en_acc_7", 32'(acc), 32'd7);
    acc_en = 1'b0;
    base   = n_beats;
    send(7'h01);
    drain();
    check("en_acc_hold", 32'(acc), 32'd7);
    check("en_beat", 32'(n_beats - base), 32'd1);

    // 6: reset with both stages full
    out_bus.ready = 1'b0;
    send(7'h7F);
    send(7'h55);
    check("rs_full_valid", 32'(out_bus.valid), 32'd1);
    check("rs_full_in_ready", 32'(in_bus.ready), 32'd0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rs_out_valid", 32'(out_bus.valid), 32'd0);
    check("rs_acc", 32'(acc), 32'd0);
    check("rs_out_count", 32'(out_bus.data), 32'd0);
    check("rs_in_ready", 32'(in_bus.ready), 32'd1);
    out_bus.ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rs_in_ready_after", 32'(in_bus.ready), 32'd1);
    base = n_beats;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rs_no_stale", 32'(out_bus.valid), 32'd0);
    end
    check("rs_beats_none", 32'(n_beats - base), 32'd0);
    @(posedge clk);
    #1;
    send(7'h55);
    drain();
    check("rs_beats_after", 32'(n_beats - base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
